// File: rtl/learning_session_ctrl.sv
// ============================================================================
// Module  : learning_session_ctrl
// Brief   : Guided-play learning controller: song select, note grading, scoring,
//           and per-song best-score memory. Optional macro: SONG_WRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module learning_session_ctrl #(
   parameter int NUM_SONGS   = 4,
   parameter int SEL_W       = 2,
   parameter int KEY_W       = 7,
   parameter int SCORE_W     = 8,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               next_song,
   input  logic               prev_song,
   input  logic               start,
   input  logic               note_valid,
   input  logic [KEY_W-1:0]   note_key,
   input  logic               note_last,
   output logic               note_ready,
   output logic [SEL_W-1:0]   song_number,
   output logic [KEY_W-1:0]   learn_show_led,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] miss_count,
   output logic [SCORE_W-1:0] best_score,
   output logic               busy,
   output logic               done
);

   localparam int                 TO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [SEL_W-1:0]   SONG_MAX = SEL_W'(NUM_SONGS - 1);
   localparam logic [SCORE_W-1:0] SAT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_GRADE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q;
   logic [SEL_W-1:0]   song_q, song_d;
   logic [KEY_W-1:0]   key_prev_q;
   logic               next_prev_q, prev_prev_q, start_prev_q;
   logic [KEY_W-1:0]   note_key_q;
   logic               note_last_q;
   logic               hit_q;
   logic [TO_W-1:0]    to_cnt_q;
   logic [SCORE_W-1:0] score_q, miss_q;
   logic [SCORE_W-1:0] best_q [NUM_SONGS];
   logic               note_ready_q, done_q;

   logic               next_rise, prev_rise, start_rise;
   logic [KEY_W-1:0]   key_new;

   assign next_rise  = next_song & ~next_prev_q;
   assign prev_rise  = prev_song & ~prev_prev_q;
   assign start_rise = start & ~start_prev_q;
   assign key_new    = key_in & ~key_prev_q;

   // Selection moves only while idle; a simultaneous next/prev cancels out.
   always_comb begin
      song_d = song_q;
      if (state_q == S_IDLE) begin
         if (next_rise && !prev_rise) begin
`ifdef SONG_WRAP_EN
            song_d = (song_q == SONG_MAX) ? '0 : song_q + 1'b1;
`else
            song_d = (song_q == SONG_MAX) ? song_q : song_q + 1'b1;
`endif
         end else if (prev_rise && !next_rise) begin
`ifdef SONG_WRAP_EN
            song_d = (song_q == '0) ? SONG_MAX : song_q - 1'b1;
`else
            song_d = (song_q == '0) ? song_q : song_q - 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         song_q       <= '0;
         key_prev_q   <= '0;
         next_prev_q  <= 1'b0;
         prev_prev_q  <= 1'b0;
         start_prev_q <= 1'b0;
         note_key_q   <= '0;
         note_last_q  <= 1'b0;
         hit_q        <= 1'b0;
         to_cnt_q     <= '0;
         score_q      <= '0;
         miss_q       <= '0;
         note_ready_q <= 1'b0;
         done_q       <= 1'b0;
         for (int i = 0; i < NUM_SONGS; i++) begin
            best_q[i] <= '0;
         end
      end else begin
         key_prev_q   <= key_in;
         next_prev_q  <= next_song;
         prev_prev_q  <= prev_song;
         start_prev_q <= start;
         song_q       <= song_d;
         note_ready_q <= 1'b0;
         done_q       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_rise) begin
                  score_q  <= '0;
                  miss_q   <= '0;
                  to_cnt_q <= '0;
                  state_q  <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (note_valid) begin
                  note_key_q  <= note_key;
                  note_last_q <= note_last;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A press in the timeout cycle takes priority over the auto-miss.
               if (|key_new) begin
                  hit_q   <= (key_new == note_key_q);
                  state_q <= S_GRADE;
               end else if (to_cnt_q == TO_LAST) begin
                  hit_q   <= 1'b0;
                  state_q <= S_GRADE;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            S_GRADE: begin
               if (hit_q) begin
                  if (score_q != SAT_MAX) score_q <= score_q + 1'b1;
               end else begin
                  if (miss_q != SAT_MAX) miss_q <= miss_q + 1'b1;
               end
               note_ready_q <= 1'b1;
               to_cnt_q     <= '0;
               state_q      <= note_last_q ? S_DONE : S_FETCH;
            end
            S_DONE: begin
               done_q <= 1'b1;
               if (score_q > best_q[song_q]) best_q[song_q] <= score_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign note_ready     = note_ready_q;
   assign done           = done_q;
   assign song_number    = song_q;
   assign score          = score_q;
   assign miss_count     = miss_q;
   assign best_score     = best_q[song_q];
   assign learn_show_led = (state_q == S_WAIT) ? note_key_q : '0;
   assign busy           = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_GRADE);

endmodule

`default_nettype wire

// File: tb/tb_learning_session_ctrl.sv
// ============================================================================
// Module  : tb_learning_session_ctrl
// Brief   : Directed table-driven bench for learning_session_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_learning_session_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] key_in;
   logic       next_song, prev_song, start;
   logic       note_valid;
   logic [6:0] note_key;
   logic       note_last;
   logic       note_ready;
   logic [1:0] song_number;
   logic [6:0] learn_show_led;
   logic [7:0] score, miss_count, best_score;
   logic       busy, done;

   int n_vec  = 0;
   int n_fail = 0;

   learning_session_ctrl #(
      .NUM_SONGS  (4),
      .SEL_W      (2),
      .KEY_W      (7),
      .SCORE_W    (8),
      .TIMEOUT_CYC(10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_in        (key_in),
      .next_song     (next_song),
      .prev_song     (prev_song),
      .start         (start),
      .note_valid    (note_valid),
      .note_key      (note_key),
      .note_last     (note_last),
      .note_ready    (note_ready),
      .song_number   (song_number),
      .learn_show_led(learn_show_led),
      .score         (score),
      .miss_count    (miss_count),
      .best_score    (best_score),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       nxt, prv, st;
      logic [6:0] key;
      logic       nv;
      logic [6:0] nkey;
      logic       nl;
      logic [1:0] e_song;
      logic [6:0] e_led;
      logic       e_busy, e_rdy, e_done;
      logic [7:0] e_score, e_miss, e_best;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(logic nxt, logic prv, logic st, logic [6:0] key,
                               logic nv, logic [6:0] nkey, logic nl,
                               logic [1:0] e_song, logic [6:0] e_led, logic e_busy,
                               logic e_rdy, logic e_done, logic [7:0] e_score,
                               logic [7:0] e_miss, logic [7:0] e_best);
      vec_t v;
      v.nxt = nxt; v.prv = prv; v.st = st; v.key = key;
      v.nv = nv; v.nkey = nkey; v.nl = nl;
      v.e_song = e_song; v.e_led = e_led; v.e_busy = e_busy;
      v.e_rdy = e_rdy; v.e_done = e_done;
      v.e_score = e_score; v.e_miss = e_miss; v.e_best = e_best;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sel_pulse(input logic n, input logic p, input logic [1:0] exp);
      next_song = n;
      prev_song = p;
      tick();
      chk("song_select", {30'd0, song_number}, {30'd0, exp});
      next_song = 1'b0;
      prev_song = 1'b0;
      tick();
   endtask

   // One-note session ending with a correct press on the given key.
   task automatic one_note_hit(input logic [6:0] k);
      start = 1'b1;
      tick();
      start = 1'b0;
      note_valid = 1'b1; note_key = k; note_last = 1'b1;
      tick();
      note_valid = 1'b0;
      key_in = k;
      tick();
      key_in = '0;
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;

      // row: nxt prv st key nv nkey nl | song led busy rdy done score miss best
      tbl[0]  = mk(0,0,1,7'h00,0,7'h00,0, 1,7'h00,1,0,0,0,0,0);
      tbl[1]  = mk(0,0,1,7'h00,1,7'h01,0, 1,7'h01,1,0,0,0,0,0);
      tbl[2]  = mk(0,0,0,7'h01,1,7'h01,0, 1,7'h00,1,0,0,0,0,0);
      tbl[3]  = mk(0,0,0,7'h01,1,7'h01,0, 1,7'h00,1,1,0,1,0,0);
      tbl[4]  = mk(0,0,0,7'h00,1,7'h04,0, 1,7'h04,1,0,0,1,0,0);
      tbl[5]  = mk(0,0,0,7'h04,1,7'h04,0, 1,7'h00,1,0,0,1,0,0);
      tbl[6]  = mk(0,0,0,7'h04,1,7'h04,0, 1,7'h00,1,1,0,2,0,0);
      tbl[7]  = mk(0,0,0,7'h00,1,7'h40,1, 1,7'h40,1,0,0,2,0,0);
      tbl[8]  = mk(0,0,0,7'h40,1,7'h40,1, 1,7'h00,1,0,0,2,0,0);
      tbl[9]  = mk(0,0,0,7'h40,1,7'h40,1, 1,7'h00,0,1,0,3,0,0);
      tbl[10] = mk(0,0,0,7'h00,0,7'h00,0, 1,7'h00,0,0,1,3,0,3);
      tbl[11] = mk(0,0,0,7'h00,0,7'h00,0, 1,7'h00,0,0,0,3,0,3);
      tbl[12] = mk(0,1,0,7'h00,0,7'h00,0, 0,7'h00,0,0,0,3,0,0);
      tbl[13] = mk(0,0,0,7'h00,0,7'h00,0, 0,7'h00,0,0,0,3,0,0);
      tbl[14] = mk(1,0,0,7'h00,0,7'h00,0, 1,7'h00,0,0,0,3,0,3);
      tbl[15] = mk(0,0,0,7'h00,0,7'h00,0, 1,7'h00,0,0,0,3,0,3);

      reset = 1'b1;
      key_in = '0; next_song = 0; prev_song = 0; start = 0;
      note_valid = 0; note_key = '0; note_last = 0;
      repeat (3) tick();
      chk("rst_song",  {30'd0, song_number}, 32'd0);
      chk("rst_score", {24'd0, score}, 32'd0);
      chk("rst_miss",  {24'd0, miss_count}, 32'd0);
      chk("rst_best",  {24'd0, best_score}, 32'd0);
      chk("rst_ctrl",  {25'd0, busy, done, note_ready, learn_show_led == 7'h00}, 32'd1);
      reset = 1'b0;
      tick();

      // Selection
`ifdef SONG_WRAP_EN
      sel_pulse(0, 1, 2'd3);
      sel_pulse(1, 0, 2'd0);
      sel_pulse(1, 0, 2'd1);
`else
      sel_pulse(1, 0, 2'd1);
      sel_pulse(1, 0, 2'd2);
      sel_pulse(1, 0, 2'd3);
      sel_pulse(1, 0, 2'd3);
      sel_pulse(1, 0, 2'd3);
      sel_pulse(0, 1, 2'd2);
      sel_pulse(0, 1, 2'd1);
      sel_pulse(0, 1, 2'd0);
      sel_pulse(0, 1, 2'd0);
      sel_pulse(1, 0, 2'd1);
`endif
      sel_pulse(1, 1, 2'd1);

      // Perfect three-note session on song 1, then check per-song best memory
      for (int i = 0; i < 16; i++) begin
         next_song = tbl[i].nxt; prev_song = tbl[i].prv; start = tbl[i].st;
         key_in = tbl[i].key; note_valid = tbl[i].nv;
         note_key = tbl[i].nkey; note_last = tbl[i].nl;
         tick();
         chk($sformatf("v%0d_song", i),  {30'd0, song_number}, {30'd0, tbl[i].e_song});
         chk($sformatf("v%0d_led", i),   {25'd0, learn_show_led}, {25'd0, tbl[i].e_led});
         chk($sformatf("v%0d_flags", i), {29'd0, busy, note_ready, done},
             {29'd0, tbl[i].e_busy, tbl[i].e_rdy, tbl[i].e_done});
         chk($sformatf("v%0d_score", i), {24'd0, score}, {24'd0, tbl[i].e_score});
         chk($sformatf("v%0d_miss", i),  {24'd0, miss_count}, {24'd0, tbl[i].e_miss});
         chk($sformatf("v%0d_best", i),  {24'd0, best_score}, {24'd0, tbl[i].e_best});
      end
      next_song = 0; prev_song = 0; start = 0; key_in = '0;
      note_valid = 0; note_key = '0; note_last = 0;
      tick();

      // Wrong key on note 1, timeout on note 2 (song 1, best stays 3)
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wt_busy", {31'd0, busy}, 32'd1);
      note_valid = 1'b1; note_key = 7'h02; note_last = 1'b0;
      tick();
      note_valid = 1'b0;
      chk("wt_led1", {25'd0, learn_show_led}, 32'h02);
      key_in = 7'h01;
      tick();
      key_in = '0;
      tick();
      chk("wt_miss1",  {24'd0, miss_count}, 32'd1);
      chk("wt_rdy1",   {31'd0, note_ready}, 32'd1);
      repeat (15) tick();
      chk("fetch_stall", {24'd0, busy, learn_show_led}, {24'd0, 1'b1, 7'h00});
      note_valid = 1'b1; note_key = 7'h08; note_last = 1'b1;
      tick();
      note_valid = 1'b0;
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         if (learn_show_led != 7'h08) break;
         waited++;
         tick();
      end
      chk("wt_timeout_cycles", waited, 32'd10);
      tick();
      tick();
      chk("wt_done",  {31'd0, done}, 32'd1);
      chk("wt_score", {24'd0, score}, 32'd0);
      chk("wt_miss2", {24'd0, miss_count}, 32'd2);
      chk("wt_best",  {24'd0, best_score}, 32'd3);

      // Correct press landing exactly on the timeout cycle (song 0)
      sel_pulse(0, 1, 2'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      note_valid = 1'b1; note_key = 7'h10; note_last = 1'b1;
      tick();
      note_valid = 1'b0;
      repeat (9) tick();
      chk("tie_still_wait", {25'd0, learn_show_led}, 32'h10);
      key_in = 7'h10;
      tick();
      key_in = '0;
      tick();
      tick();
      chk("tie_done",  {31'd0, done}, 32'd1);
      chk("tie_score", {24'd0, score}, 32'd1);
      chk("tie_miss",  {24'd0, miss_count}, 32'd0);
      chk("tie_best",  {24'd0, best_score}, 32'd1);

      // Equal score does not rewrite, verified by a repeat then reset clearing
      one_note_hit(7'h20);
      chk("eq_best", {24'd0, best_score}, 32'd1);

      // Reset mid-session after one hit on song 2
      sel_pulse(1, 0, 2'd1);
      sel_pulse(1, 0, 2'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      note_valid = 1'b1; note_key = 7'h01; note_last = 1'b0;
      tick();
      note_valid = 1'b0;
      key_in = 7'h01;
      tick();
      key_in = '0;
      tick();
      chk("mid_score", {24'd0, score}, 32'd1);
      note_valid = 1'b1; note_key = 7'h02;
      tick();
      reset = 1'b1;
      note_valid = 1'b0;
      tick();
      reset = 1'b0;
      chk("mr_song",  {30'd0, song_number}, 32'd0);
      chk("mr_score", {24'd0, score}, 32'd0);
      chk("mr_miss",  {24'd0, miss_count}, 32'd0);
      chk("mr_best0", {24'd0, best_score}, 32'd0);
      chk("mr_ctrl",  {25'd0, busy, done, note_ready, learn_show_led == 7'h00}, 32'd1);
      tick();
      sel_pulse(1, 0, 2'd1);
      sel_pulse(1, 0, 2'd2);
      chk("mr_best2", {24'd0, best_score}, 32'd0);
      one_note_hit(7'h20);
      chk("post_done",  {31'd0, done}, 32'd1);
      chk("post_score", {24'd0, score}, 32'd1);
      chk("post_best",  {24'd0, best_score}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
